fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have imemReqValid  output  1  fetch request valid.
REQ-007 SHALL have imemReqReady  input  1  memory accepts request.
REQ-008 SHALL have imemAddr  output  XLEN  request address.
REQ-009 SHALL have imemRespValid  input  1  response data valid; in order, no backpressure.
REQ-010 SHALL have imemRdata  input  XLEN  response instruction.
REQ-011 SHALL have redirect  input  1  branch/jump taken in execute.
REQ-012 SHALL have redirectPc  input  XLEN  redirect target.
REQ-013 SHALL have instrValid  output  1  queue head valid to decode.
REQ-014 SHALL have instrReady  input  1  decode consumes head (low = stall).
REQ-015 SHALL have instrD, pcD, pcDplus4  output  XLEN each  head instruction, its address, address+4.

Function
REQ-016 SHALL accept a request when imemReqValid && imemReqReady; imemAddr = fetchPc; fetchPc += 4 on accept, modulo 2^XLEN.
REQ-017 SHALL drive imemReqValid = !redirect && (count + outstanding) < DEPTH; imemAddr held stable while valid && !ready.
REQ-018 SHALL track outstanding (width clog2(DEPTH)+1): +1 on accept, -1 on response, unchanged when both in one cycle.
REQ-019 SHALL track respPc: address of oldest outstanding request; +4 per response received.
REQ-020 SHALL push each non-dropped response into the queue tail as {imemRdata, respPc}; the entry is visible at the head no earlier than the next cycle (no bypass).
REQ-021 SHALL drive instrValid = (count != 0); instrD/pcD from head; pcDplus4 = pcD + 4; all three 0 when empty.
REQ-022 SHALL pop the head on instrValid && instrReady; push and pop in one cycle leave count unchanged.
REQ-023 SHALL never overflow: credit rule of REQ-017 guarantees a slot per outstanding request.
REQ-024 On redirect, SHALL in that cycle: empty the queue (pop ignored), set fetchPc and respPc to {redirectPc[XLEN-1:2], 2'b00}, set dropCount to outstanding minus any response arriving that cycle, and discard that response.
REQ-025 While dropCount != 0, SHALL discard each response and decrement dropCount; outstanding still decrements.
REQ-026 SHALL issue the first post-redirect request the cycle after redirect, even while dropCount != 0, subject to REQ-017.
REQ-027 Redirect while dropCount != 0 SHALL set dropCount to all outstanding again (REQ-024 rule).

Reset
REQ-028 rst asserted SHALL immediately force fetchPc = respPc = RESET_PC, count = outstanding = dropCount = 0, imemReqValid = 0, instrValid = 0, instrD = pcD = 0, pcDplus4 = 4.
REQ-029 Reset mid-operation SHALL abandon in-flight requests; bench SHALL not return responses for them after release.
REQ-030 First request SHALL issue in the first cycle after rst deasserts, address RESET_PC.

Verification
REQ-031 Single-cycle memory, instrReady=1 -> requests 0x0,0x4,0x8... each one per cycle; instrValid high from cycle 3; pcD sequence 0x0,0x4,0x8.
REQ-032 instrReady=0, memory latency 1, DEPTH=4 -> exactly 4 requests accepted, queue full, imemReqValid=0; raise instrReady -> one new request per pop.
REQ-033 Latency-3 memory, 2 outstanding, redirect to 0x100 -> both stale responses dropped, queue empty, next request 0x100, first instrValid pcD=0x100.
REQ-034 Redirect to 0x203 same cycle as response and pop -> response discarded, queue empty, next imemAddr = 0x200.
REQ-035 RESET_PC = 0xFFFFFFFC -> second request address 0x00000000 (wrap); pcDplus4 of first entry = 0x0.
REQ-036 Assert rst with queue holding 3 entries -> instrValid and imemReqValid fall without a clock edge; after release first imemAddr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Handshake bundle between the fetch unit, instruction memory and decode.
// master = fetch unit side, slave = memory/decode/execute side.
interface fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imemReqValid;
    logic            imemReqReady;
    logic [XLEN-1:0] imemAddr;
    logic            imemRespValid;
    logic [XLEN-1:0] imemRdata;
    logic            redirect;
    logic [XLEN-1:0] redirectPc;
    logic            instrValid;
    logic            instrReady;
    logic [XLEN-1:0] instrD;
    logic [XLEN-1:0] pcD;
    logic [XLEN-1:0] pcDplus4;

    modport master (
        output imemReqValid, imemAddr, instrValid, instrD, pcD, pcDplus4,
        input  imemReqReady, imemRespValid, imemRdata, redirect, redirectPc, instrReady
    );

    modport slave (
        input  imemReqValid, imemAddr, instrValid, instrD, pcD, pcDplus4,
        output imemReqReady, imemRespValid, imemRdata, redirect, redirectPc, instrReady
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to instruction memory, in-order
// response queue to decode, redirect with squash of in-flight responses.
module fetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int unsigned PTRW = $clog2(DEPTH);
    localparam int unsigned CNTW = PTRW + 1;
    localparam int unsigned SUMW = CNTW + 1;

    logic [XLEN-1:0] fetchPc;
    logic [XLEN-1:0] respPc;
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] outstanding;
    logic [CNTW-1:0] dropCount;
    logic [PTRW-1:0] headPtr;
    logic [PTRW-1:0] tailPtr;
    logic [XLEN-1:0] instrMem [DEPTH];
    logic [XLEN-1:0] pcMem    [DEPTH];

    logic            reqValid;
    logic            reqFire;
    logic            respKeep;
    logic            popFire;
    logic            headValid;
    logic [XLEN-1:0] redirectBase;
    logic [XLEN-1:0] headPc;

    // Every request in flight owns a queue slot, so the queue cannot overflow.
    assign reqValid     = !rst && !bus.redirect &&
                          ((SUMW'(count) + SUMW'(outstanding)) < SUMW'(DEPTH));
    assign reqFire      = reqValid && bus.imemReqReady;
    assign respKeep     = bus.imemRespValid && !bus.redirect && (dropCount == '0);
    assign headValid    = (count != '0);
    assign popFire      = headValid && bus.instrReady && !bus.redirect;
    assign redirectBase = bus.redirectPc & ~XLEN'(3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetchPc     <= RESET_PC;
            respPc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            dropCount   <= '0;
            headPtr     <= '0;
            tailPtr     <= '0;
        end else begin
            outstanding <= outstanding + CNTW'(reqFire) - CNTW'(bus.imemRespValid);
            if (bus.redirect) begin
                // Everything still in flight belongs to the squashed path.
                fetchPc   <= redirectBase;
                respPc    <= redirectBase;
                dropCount <= outstanding - CNTW'(bus.imemRespValid);
                count     <= '0;
                headPtr   <= '0;
                tailPtr   <= '0;
            end else begin
                if (reqFire) begin
                    fetchPc <= fetchPc + XLEN'(4);
                end
                if (respKeep) begin
                    respPc  <= respPc + XLEN'(4);
                    tailPtr <= tailPtr + PTRW'(1);
                end
                if (bus.imemRespValid && (dropCount != '0)) begin
                    dropCount <= dropCount - CNTW'(1);
                end
                if (popFire) begin
                    headPtr <= headPtr + PTRW'(1);
                end
                count <= count + CNTW'(respKeep) - CNTW'(popFire);
            end
        end
    end

    // Queue storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (respKeep) begin
            instrMem[tailPtr] <= bus.imemRdata;
            pcMem[tailPtr]    <= respPc;
        end
    end

    assign headPc           = headValid ? pcMem[headPtr] : '0;
    assign bus.imemReqValid = reqValid;
    assign bus.imemAddr     = fetchPc;
    assign bus.instrValid   = headValid;
    assign bus.instrD       = headValid ? instrMem[headPtr] : '0;
    assign bus.pcD          = headPc;
    assign bus.pcDplus4     = headPc + XLEN'(4);
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model feeds the
// DUT while a monitor checks accepted requests and delivered instructions.
module tb_fetch_unit;
    logic clk;
    logic rst;

    fetch_unit_if #(.XLEN(32)) bus  ();
    fetch_unit_if #(.XLEN(32)) busW ();

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dutW (
        .clk (clk),
        .rst (rst),
        .bus (busW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } memEnt_t;

    int          nTests;
    int          nFail;
    int          cyc;
    int          lat;
    int          reqBudget;
    int          reqAcc;
    memEnt_t     respQ[$];
    logic [31:0] expAddrQ[$];
    logic [31:0] expPcQ[$];
    logic [31:0] expInstrQ[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic expAddr(input logic [31:0] a);
        expAddrQ.push_back(a);
    endtask

    task automatic expInstr(input logic [31:0] pc, input logic [31:0] ins);
        expPcQ.push_back(pc);
        expInstrQ.push_back(ins);
    endtask

    task automatic checkDrained(input string tag);
        check({tag, "_addrLeft"}, 32'(expAddrQ.size()), 32'd0);
        check({tag, "_instrLeft"}, 32'(expInstrQ.size()), 32'd0);
    endtask

    // One cycle: drive inputs at negedge, memory answers in order after lat cycles.
    task automatic step(input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        cyc++;
        bus.redirect     = redir;
        bus.redirectPc   = rpc;
        bus.instrReady   = rdy;
        bus.imemReqReady = (reqBudget > 0);
        if (respQ.size() != 0 && respQ[0].due == cyc) begin
            bus.imemRespValid = 1'b1;
            bus.imemRdata     = respQ[0].addr ^ 32'hDEAD_0000;
            respQ.delete(0);
        end else begin
            bus.imemRespValid = 1'b0;
            bus.imemRdata     = '0;
        end
        #1;
        if (bus.imemReqValid && bus.imemReqReady) begin
            respQ.push_back('{addr: bus.imemAddr, due: cyc + lat});
            reqBudget--;
            reqAcc++;
        end
    endtask

    task automatic stepW(input logic rv, input logic [31:0] rd, input logic rdy, input logic memRdy);
        @(negedge clk);
        busW.imemRespValid = rv;
        busW.imemRdata     = rd;
        busW.instrReady    = rdy;
        busW.imemReqReady  = memRdy;
        #1;
    endtask

    // Responses to requests abandoned by reset are never returned.
    task automatic doReset();
        rst = 1'b1;
        respQ.delete();
        reqBudget         = 0;
        reqAcc            = 0;
        bus.imemReqReady  = 1'b0;
        bus.imemRespValid = 1'b0;
        bus.imemRdata     = '0;
        bus.redirect      = 1'b0;
        bus.redirectPc    = '0;
        bus.instrReady    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Scoreboard monitor, sampling in the low phase after inputs settle.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && bus.imemReqValid && bus.imemReqReady) begin
                check("reqExpected", 32'(expAddrQ.size() != 0), 32'd1);
                if (expAddrQ.size() != 0) begin
                    check("reqAddr", bus.imemAddr, expAddrQ.pop_front());
                end
            end
            if (!rst && bus.instrValid && bus.instrReady && !bus.redirect) begin
                check("instrExpected", 32'(expInstrQ.size() != 0), 32'd1);
                if (expInstrQ.size() != 0) begin
                    check("instrPc", bus.pcD, expPcQ.pop_front());
                    check("instrData", bus.instrD, expInstrQ.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nTests = 0; nFail = 0; cyc = 0; lat = 1; reqBudget = 0; reqAcc = 0;
        rst = 1'b1;
        bus.imemReqReady  = 1'b0; bus.imemRespValid  = 1'b0; bus.imemRdata  = '0;
        bus.redirect      = 1'b0; bus.redirectPc     = '0;   bus.instrReady = 1'b0;
        busW.imemReqReady = 1'b0; busW.imemRespValid = 1'b0; busW.imemRdata = '0;
        busW.redirect     = 1'b0; busW.redirectPc    = '0;   busW.instrReady = 1'b0;
        #3;
        check("rstReqValid", 32'(bus.imemReqValid), 32'd0);
        check("rstInstrValid", 32'(bus.instrValid), 32'd0);
        check("rstInstrD", bus.instrD, 32'h0);
        check("rstPcD", bus.pcD, 32'h0);
        check("rstPcDplus4", bus.pcDplus4, 32'h4);

        // Single-cycle memory, decode always ready.
        doReset();
        lat = 1; reqBudget = 3;
        expAddr(32'h0); expAddr(32'h4); expAddr(32'h8);
        expInstr(32'h0, 32'hDEAD_0000);
        expInstr(32'h4, 32'hDEAD_0004);
        expInstr(32'h8, 32'hDEAD_0008);
        step(1'b0, '0, 1'b1);
        check("aFirstAddr", bus.imemAddr, 32'h0);
        check("aFirstValid", 32'(bus.imemReqValid), 32'd1);
        step(1'b0, '0, 1'b1);
        check("aValidC2", 32'(bus.instrValid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("aValidC3", 32'(bus.instrValid), 32'd1);
        check("aPcDplus4C3", bus.pcDplus4, 32'h4);
        repeat (5) step(1'b0, '0, 1'b1);
        checkDrained("a");

        // Decode stalled: credits cap requests at the queue depth.
        doReset();
        lat = 1; reqBudget = 6;
        expAddr(32'h0); expAddr(32'h4); expAddr(32'h8);
        expAddr(32'hC); expAddr(32'h10); expAddr(32'h14);
        expInstr(32'h0,  32'hDEAD_0000); expInstr(32'h4,  32'hDEAD_0004);
        expInstr(32'h8,  32'hDEAD_0008); expInstr(32'hC,  32'hDEAD_000C);
        expInstr(32'h10, 32'hDEAD_0010); expInstr(32'h14, 32'hDEAD_0014);
        repeat (8) step(1'b0, '0, 1'b0);
        check("bAccepted", 32'(reqAcc), 32'd4);
        check("bFullReqValid", 32'(bus.imemReqValid), 32'd0);
        check("bFullInstrValid", 32'(bus.instrValid), 32'd1);
        step(1'b0, '0, 1'b1);
        check("bPopCycleReqValid", 32'(bus.imemReqValid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("bAfterPopReqValid", 32'(bus.imemReqValid), 32'd1);
        check("bAfterPopAccepted", 32'(reqAcc), 32'd5);
        repeat (10) step(1'b0, '0, 1'b1);
        checkDrained("b");

        // Latency 3, two requests in flight, redirect squashes both.
        doReset();
        lat = 3; reqBudget = 2;
        expAddr(32'h0); expAddr(32'h4); expAddr(32'h100); expAddr(32'h104);
        expInstr(32'h100, 32'hDEAD_0100);
        expInstr(32'h104, 32'hDEAD_0104);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        reqBudget = 2;
        step(1'b1, 32'h100, 1'b1);
        check("cRedirReqValid", 32'(bus.imemReqValid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("cAddrAfterRedir", bus.imemAddr, 32'h100);
        check("cEmptyC4", 32'(bus.instrValid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("cEmptyC5", 32'(bus.instrValid), 32'd0);
        step(1'b0, '0, 1'b1);
        check("cEmptyC6", 32'(bus.instrValid), 32'd0);
        repeat (6) step(1'b0, '0, 1'b1);
        checkDrained("c");

        // Redirect to a misaligned target coinciding with a response and a pop.
        doReset();
        lat = 1; reqBudget = 2;
        expAddr(32'h0); expAddr(32'h4); expAddr(32'h200);
        expInstr(32'h200, 32'hDEAD_0200);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        reqBudget = 1;
        step(1'b1, 32'h203, 1'b1);
        check("dRespInRedir", 32'(bus.imemRespValid), 32'd1);
        step(1'b0, '0, 1'b1);
        check("dEmptyAfterRedir", 32'(bus.instrValid), 32'd0);
        check("dAlignedAddr", bus.imemAddr, 32'h200);
        repeat (5) step(1'b0, '0, 1'b1);
        checkDrained("d");

        // Reset with three queued entries: outputs drop without a clock edge.
        doReset();
        lat = 1; reqBudget = 3;
        expAddr(32'h0); expAddr(32'h4); expAddr(32'h8);
        repeat (5) step(1'b0, '0, 1'b0);
        check("eQueued", 32'(bus.instrValid), 32'd1);
        rst = 1'b1;
        #1;
        check("eAsyncInstrValid", 32'(bus.instrValid), 32'd0);
        check("eAsyncReqValid", 32'(bus.imemReqValid), 32'd0);
        check("eAsyncPcD", bus.pcD, 32'h0);
        check("eAsyncPcDplus4", bus.pcDplus4, 32'h4);
        doReset();
        lat = 1; reqBudget = 1;
        expAddr(32'h0);
        expInstr(32'h0, 32'hDEAD_0000);
        step(1'b0, '0, 1'b1);
        check("eFirstAddr", bus.imemAddr, 32'h0);
        check("eFirstValid", 32'(bus.imemReqValid), 32'd1);
        repeat (4) step(1'b0, '0, 1'b1);
        checkDrained("e");

        // Address wrap from the top of the address space.
        doReset();
        stepW(1'b0, 32'h0, 1'b0, 1'b1);
        check("wFirstValid", 32'(busW.imemReqValid), 32'd1);
        check("wFirstAddr", busW.imemAddr, 32'hFFFF_FFFC);
        stepW(1'b1, 32'h1111_1111, 1'b0, 1'b1);
        check("wSecondAddr", busW.imemAddr, 32'h0000_0000);
        stepW(1'b1, 32'h2222_2222, 1'b0, 1'b0);
        check("wHeadValid", 32'(busW.instrValid), 32'd1);
        check("wHeadPc", busW.pcD, 32'hFFFF_FFFC);
        check("wHeadInstr", busW.instrD, 32'h1111_1111);
        check("wHeadPcPlus4", busW.pcDplus4, 32'h0000_0000);
        stepW(1'b0, 32'h0, 1'b1, 1'b0);
        check("wSecondPc", busW.pcD, 32'hFFFF_FFFC);
        stepW(1'b0, 32'h0, 1'b1, 1'b0);
        check("wNextPc", busW.pcD, 32'h0000_0000);
        check("wNextInstr", busW.instrD, 32'h2222_2222);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
